fir_output_stage: RTL
=====================

# fir_output_stage

Output stage that sits directly downstream of the last MAC cell in the FIR systolic chain. It consumes the chain's accumulated `c_out` and re-aligns it with a delayed input-valid strobe. It then saturates the sum to the output word width, decimates by a programmable factor, and buffers kept samples in a small FIFO. The FIFO is read by the consumer over a valid/ready handshake.

## Interface
- `C_WIDTH`, 12: width of the accumulated sum from the MAC chain.
- `OUT_W`, 10: output sample width; must be ≤ `C_WIDTH`.
- `PIPE_LAT`, 4: cycles from `in_valid` to the matching `c_in` being stable.
- `FIFO_DEPTH`, 4: output buffer entries; power of two, ≥ 2.
- `DEC_W`, 4: width of the decimation control.

Ports:
- `clock`, in, 1: single clock; all logic is on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `in_valid`, in, 1: strobe marking a new sample entering the MAC chain.
- `c_in`, in, `C_WIDTH`, signed: `c_out` of the last MAC.
- `decim`, in, `DEC_W`: decimation factor minus one (0 = keep every sample).
- `clear_flags`, in, 1: synchronous clear of the sticky flags.
- `out_data`, out, `OUT_W`, signed: head of the FIFO; 0 when empty.
- `out_valid`, out, 1: FIFO not empty.
- `out_ready`, in, 1: consumer accepts the head on a cycle where `out_valid`=1.
- `level`, out, `$clog2(FIFO_DEPTH+1)`: current FIFO occupancy.
- `sat_flag`, out, 1: sticky; set when a kept sample was clipped.
- `overflow`, out, 1: sticky; set when a kept sample was dropped because the FIFO was full.

## Operation
- **Alignment.** A `PIPE_LAT`-deep shift register delays `in_valid` to give `aligned_v`. `c_in` is sampled only on cycles where `aligned_v`=1.
- **Decimation.**
  - Counter `dcnt` runs from 0 to the latched factor and wraps to 0.
  - A sample is kept when `aligned_v`=1 and `dcnt`==0.
  - `dcnt` advances only on `aligned_v` cycles.
  - `decim` is latched into the factor register at reset release and at every wrap to 0. A change to `decim` mid-period takes effect after the current period.
  - The first aligned sample after reset is always kept.
- **Saturation.**
  - Kept samples above 2^(OUT_W-1)-1 clip to that maximum.
  - Kept samples below -2^(OUT_W-1) clip to that minimum.
  - Any other kept sample passes through as `c_in[OUT_W-1:0]`.
  - Any clip sets `sat_flag`.
  - Samples that are not kept never set flags.
- **Saturation register.** The kept, saturated value goes into a one-entry register `s_v`/`s_data`. On the next cycle it is pushed into the FIFO.
- **FIFO behaviour.**
  - Push while not full: the sample is written.
  - Push while full with no pop: the sample is discarded, `overflow` is set, and contents are unchanged.
  - Push and pop on the same cycle while full: both occur, and `level` stays at `FIFO_DEPTH`.
  - Pop while empty: ignored.
  - Read and write pointers wrap modulo `FIFO_DEPTH`.
- **Flags.** `clear_flags` clears both flags. If a set event happens on the same cycle as `clear_flags`, the set wins.
- **Reset, at any time, including mid-stream.**
  - The valid shift register, `dcnt`, the factor register, `s_v`, both pointers and both flags all go to 0.
  - `out_valid`=0, `out_data`=0, `level`=0.
  - In-flight samples are lost.

## Timing
- Edge 0 is the edge where `in_valid`=1 is sampled.
- At edge `PIPE_LAT`, `aligned_v` is high and `c_in` is sampled into `s_data`.
- At edge `PIPE_LAT`+1, `s_data` is written into the FIFO.
- `out_valid` is high after edge `PIPE_LAT`+1, so end-to-end latency is `PIPE_LAT`+2 cycles.
- `sat_flag` is visible after edge `PIPE_LAT`.
- `overflow` is visible after the push edge that drops the sample.
- `out_data` and `out_valid` are combinational from FIFO state, with no combinational path from `out_ready`.
- A pop occurs at the edge where `out_valid`&&`out_ready`. The next head appears after that edge.
- Throughput is one sample per cycle when `decim`=0 and `out_ready`=1.
- `level` updates at the same edge as the push or pop.

## Test plan
1. **Pass-through.** `decim`=0, `out_ready`=1; `in_valid` pulses with `c_in` = 100, -200, 511.
   - Required: `out_data` = 100, -200, 511, each `PIPE_LAT`+2 cycles after its `in_valid`.
   - Required: `sat_flag`=0.
2. **Saturation.** `c_in` = 700, then -1000.
   - Required: outputs 511 and -512, with `sat_flag`=1 after the first.
   - Then pulse `clear_flags` → `sat_flag`=0.
   - Then `clear_flags` on the same cycle as a clip of 600 → `sat_flag` stays 1.
3. **Decimation.** `decim`=2; nine consecutive aligned samples 1..9.
   - Required: outputs are 1, 4, 7.
   - Change `decim` to 0 while the sample-5 cycle is aligned. Required: the new factor applies only after the wrap, so 7 is output, then every following sample.
4. **Overflow.** `out_ready`=0; push 5 kept samples 10..14.
   - Required: `level`=4, `overflow`=1, and 14 is dropped.
   - Then set `out_ready`=1. Required: 10, 11, 12, 13 drain; `out_valid`=0 and `out_data`=0 afterwards.
5. **Full push+pop.** FIFO full with `out_ready`=1 while a new sample 20 is pushed.
   - Required: `level` stays 4, `overflow` does not set, and 20 appears after the 3 remaining older entries.
6. **Reset mid-stream.** Assert `reset` asynchronously, between edges, with 3 entries queued and samples in flight.
   - Required: `out_valid`, `level` and both flags go to 0 immediately.
   - Required: after release, the first aligned sample is kept, and no stale sample is emitted.

Source files
------------

// File: rtl/fir_output_stage.sv
// fir_output_stage: output stage after the last MAC cell of the FIR chain.
// It delays in_valid to line it up with the accumulated sum, then decimates.
// It saturates each kept sample to OUT_W bits and queues it in a small FIFO.
// The consumer drains the FIFO over a valid/ready handshake.
module fir_output_stage #(
  parameter int C_WIDTH    = 12,
  parameter int OUT_W      = 10,
  parameter int PIPE_LAT   = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int DEC_W      = 4
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               in_valid,
  input  logic signed [C_WIDTH-1:0]          c_in,
  input  logic [DEC_W-1:0]                   decim,
  input  logic                               clear_flags,
  output logic signed [OUT_W-1:0]            out_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    level,
  output logic                               sat_flag,
  output logic                               overflow
);

  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic signed [C_WIDTH-1:0] SAT_MAX = C_WIDTH'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [C_WIDTH-1:0] SAT_MIN = C_WIDTH'(-(2 ** (OUT_W - 1)));

  logic [PIPE_LAT-1:0]     vld_q, vld_d;
  logic [DEC_W-1:0]        dcnt_q, dcnt_d;
  logic [DEC_W-1:0]        factor_q, factor_d;
  logic                    load_q, load_d;
  logic                    s_v_q, s_v_d;
  logic signed [OUT_W-1:0] s_data_q, s_data_d;
  logic signed [OUT_W-1:0] mem_q [FIFO_DEPTH];
  logic signed [OUT_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]        count_q, count_d;
  logic                    sat_flag_q, sat_flag_d;
  logic                    overflow_q, overflow_d;

  logic                    aligned_v;
  logic                    keep;
  logic                    clip_hi, clip_lo;
  logic signed [OUT_W-1:0] sat_val;
  logic                    pop, full, wr_en, drop;

  assign aligned_v = vld_q[PIPE_LAT-1];
  assign keep      = aligned_v && (dcnt_q == '0);

  // Clip the incoming sum to the signed OUT_W range.
  always_comb begin
    clip_hi = (c_in > SAT_MAX);
    clip_lo = (c_in < SAT_MIN);
    if (clip_hi) begin
      sat_val = {1'b0, {(OUT_W - 1){1'b1}}};
    end else if (clip_lo) begin
      sat_val = {1'b1, {(OUT_W - 1){1'b0}}};
    end else begin
      sat_val = c_in[OUT_W-1:0];
    end
  end

  // Next-state logic: alignment, decimation, staging register, FIFO and flags.
  always_comb begin
    vld_d    = vld_q << 1;
    vld_d[0] = in_valid;

    // The factor is only reloaded at a period boundary (or the first cycle
    // after reset), so a decim change never truncates a period in progress.
    dcnt_d   = dcnt_q;
    factor_d = factor_q;
    load_d   = 1'b0;
    if (aligned_v) begin
      if (dcnt_q == factor_q) begin
        dcnt_d   = '0;
        factor_d = decim;
      end else begin
        dcnt_d = dcnt_q + DEC_W'(1);
      end
    end
    if (load_q) begin
      factor_d = decim;
    end

    s_v_d    = keep;
    s_data_d = keep ? sat_val : s_data_q;

    // A pop frees a slot on the same edge, so a full FIFO still accepts a push when it is also popped.
    pop   = out_valid && out_ready;
    full  = (count_q == LVL_W'(FIFO_DEPTH));
    wr_en = s_v_q && (!full || pop);
    drop  = s_v_q && full && !pop;

    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = s_data_q;
    end
    wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    count_d = count_q;
    if (wr_en && !pop) begin
      count_d = count_q + LVL_W'(1);
    end else if (!wr_en && pop) begin
      count_d = count_q - LVL_W'(1);
    end

    // A set event on the same cycle as clear_flags wins.
    sat_flag_d = sat_flag_q;
    overflow_d = overflow_q;
    if (clear_flags) begin
      sat_flag_d = 1'b0;
      overflow_d = 1'b0;
    end
    if (keep && (clip_hi || clip_lo)) begin
      sat_flag_d = 1'b1;
    end
    if (drop) begin
      overflow_d = 1'b1;
    end
  end

  // State registers; reset drops everything in flight and arms the factor load.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_q      <= '0;
      dcnt_q     <= '0;
      factor_q   <= '0;
      load_q     <= 1'b1;
      s_v_q      <= 1'b0;
      s_data_q   <= '0;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      sat_flag_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      vld_q      <= vld_d;
      dcnt_q     <= dcnt_d;
      factor_q   <= factor_d;
      load_q     <= load_d;
      s_v_q      <= s_v_d;
      s_data_q   <= s_data_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      sat_flag_q <= sat_flag_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign level     = count_q;
  assign sat_flag  = sat_flag_q;
  assign overflow  = overflow_q;

endmodule
